// File: rtl/sram_data_controller.sv
// MEM-stage data-memory responder: services 32-bit word requests on a 16-bit
// asynchronous SRAM as two half-word accesses, stalling the pipeline via ready.
module sram_data_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int unsigned CNT_W   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int unsigned WIDX_W  = 17;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_wr_q;
    logic [31:0]        read_data_q;
    logic [17:0]        addr_q;
    logic               we_n_q;
    logic               dq_oe_q;
    logic [15:0]        dq_out_q;

    logic [31:0]        off;
    logic [WIDX_W-1:0]  word_idx;
    logic               req;
    logic               unused_off;

    // Out-of-range addresses wrap: only the half-word-pair index is kept.
    assign off        = address - BASE_ADDR;
    assign word_idx   = off[18:2];
    assign unused_off = ^{off[31:19], off[1:0]};
    assign req        = rd_en | wr_en;

    // Combinational on the request so the pipeline freezes in the request cycle.
    assign ready = ~req | (state_q == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
            addr_q      <= '0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q  <= ST_LOW;
                        cnt_q    <= '0;
                        is_wr_q  <= wr_en;
                        addr_q   <= {word_idx, 1'b0};
                        we_n_q   <= ~wr_en;
                        dq_oe_q  <= wr_en;
                        dq_out_q <= write_data[15:0];
                    end
                end
                ST_LOW: begin
                    if (cnt_q == CNT_LAST) begin
                        if (!is_wr_q) begin
                            read_data_q[15:0] <= SRAM_DQ;
                        end
                        state_q  <= ST_HIGH;
                        cnt_q    <= '0;
                        addr_q   <= {word_idx, 1'b1};
                        dq_out_q <= write_data[31:16];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == CNT_LAST) begin
                        if (!is_wr_q) begin
                            read_data_q[31:16] <= SRAM_DQ;
                        end
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_data_controller.sv
// Directed bench for sram_data_controller with a small behavioural 16-bit SRAM
// model on the DQ bus.
module tb_sram_data_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    logic [15:0] mem [16];
    logic        mem_clr;
    logic        probe;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat;

    always #5 clk = ~clk;

    sram_data_controller dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    // SRAM model: reads drive the bus whenever WE_N is high; writes commit on
    // each clock edge that sees WE_N low. probe replaces read data with a marker.
    assign sram_dq = (sram_we_n && !sram_oe_n && !sram_ce_n)
                     ? (probe ? 16'hA5A5 : mem[sram_addr[3:0]]) : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'hC000 | 16'(i);
        end else if (!sram_we_n && !sram_ce_n) begin
            mem[sram_addr[3:0]] <= sram_dq;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first ready cycle.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int cycles);
        rd_en      = rd;
        wr_en      = wr;
        address    = a;
        write_data = d;
        cycles     = 0;
        #1;
        while (!ready && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        mem_clr = 1'b1; probe = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_rdata", read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        #1;
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        chk("idle_rdata", read_data, 32'd0);
        chk("tie_lows", 32'({sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}), 32'd0);
        probe = 1'b1;
        #1;
        chk("idle_dq_released", 32'(sram_dq), 32'h0000A5A5);
        probe = 1'b0;

        // Write 0x12345678 at 1024, cycle by cycle
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1024; write_data = 32'h12345678;
        #1;
        chk("wr_c0_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("wr_c1_addr", 32'(sram_addr), 32'd0);
        chk("wr_c1_we_n", 32'(sram_we_n), 32'd0);
        chk("wr_c1_dq", 32'(sram_dq), 32'h00005678);
        chk("wr_c1_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("wr_c2_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("wr_c3_addr", 32'(sram_addr), 32'd1);
        chk("wr_c3_we_n", 32'(sram_we_n), 32'd0);
        chk("wr_c3_dq", 32'(sram_dq), 32'h00001234);
        @(negedge clk);
        chk("wr_c4_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("wr_c5_ready", 32'(ready), 32'd1);
        chk("wr_c5_we_n", 32'(sram_we_n), 32'd1);
        chk("wr_c5_addr", 32'(sram_addr), 32'd0);
        wr_en = 1'b0;
        chk("wr_mem0", 32'(mem[0]), 32'h00005678);
        chk("wr_mem1", 32'(mem[1]), 32'h00001234);

        // Read it back; ready must drop again once DONE has passed
        @(negedge clk);
        run_req(1'b1, 1'b0, 32'd1024, 32'd0, lat);
        chk("rd0_latency", 32'(lat), 32'd5);
        chk("rd0_data", read_data, 32'h12345678);
        @(negedge clk);
        chk("rd0_ready_one_cycle", 32'(ready), 32'd0);
        rd_en = 1'b0;
        #1;
        chk("rd0_ready_release", 32'(ready), 32'd1);

        @(negedge clk);
        run_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lat);
        wr_en = 1'b0;
        chk("wr1_latency", 32'(lat), 32'd5);
        chk("wr1_mem2", 32'(mem[2]), 32'h0000BEEF);
        chk("wr1_mem3", 32'(mem[3]), 32'h0000DEAD);
        chk("wr1_rdata_kept", read_data, 32'h12345678);

        // Back-to-back reads, second raised in the cycle after DONE
        @(negedge clk);
        run_req(1'b1, 1'b0, 32'd1028, 32'd0, lat);
        chk("b2b_a_latency", 32'(lat), 32'd5);
        chk("b2b_a_data", read_data, 32'hDEADBEEF);
        @(negedge clk);
        run_req(1'b1, 1'b0, 32'd1024, 32'd0, lat);
        chk("b2b_b_latency", 32'(lat), 32'd5);
        chk("b2b_b_data", read_data, 32'h12345678);
        rd_en = 1'b0;

        // Address beyond the 512 KiB window wraps onto word 1
        @(negedge clk);
        run_req(1'b1, 1'b0, 32'd1028 + 32'h00080000, 32'd0, lat);
        rd_en = 1'b0;
        chk("wrap_data", read_data, 32'hDEADBEEF);

        // Reset during the HIGH half of a write
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hAAAA5555;
        repeat (3) @(negedge clk);
        chk("mid_high_addr", 32'(sram_addr), 32'd5);
        chk("mid_high_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_rst_addr", 32'(sram_addr), 32'd0);
        chk("mid_rst_rdata", read_data, 32'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_mem4", 32'(mem[4]), 32'h00005555);
        chk("mid_rst_mem5", 32'(mem[5]), 32'h0000C005);
        @(negedge clk);
        run_req(1'b1, 1'b0, 32'd1032, 32'd0, lat);
        rd_en = 1'b0;
        chk("post_rst_latency", 32'(lat), 32'd5);
        chk("post_rst_data", read_data, 32'hC0055555);

        // Simultaneous rd_en/wr_en behaves as a write
        @(negedge clk);
        run_req(1'b1, 1'b1, 32'd1036, 32'h0F0F0F0F, lat);
        rd_en = 1'b0; wr_en = 1'b0;
        chk("both_latency", 32'(lat), 32'd5);
        chk("both_mem6", 32'(mem[6]), 32'h00000F0F);
        chk("both_mem7", 32'(mem[7]), 32'h00000F0F);
        chk("both_rdata_kept", read_data, 32'hC0055555);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_data_controller.md
# sram_data_controller

Responder side of the MEM-stage data-memory interface: accepts 32-bit word read/write requests from the MEM stage and services them on an external 16-bit asynchronous SRAM as two half-word accesses. While a request is in progress it deasserts `ready`. The system top uses `ready` to freeze every pipeline register and the PC. The block sits between the MEM stage and the board SRAM pins and replaces the single-cycle internal data memory.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: CPU byte address that maps to SRAM word 0.
- `ACCESS_CYCLES`, default 2: clock cycles spent on each 16-bit SRAM access (≥1).

Ports:
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rd_en`  in  1: MEM-stage read request; held until `ready`.
- `wr_en`  in  1: MEM-stage write request; held until `ready`.
- `address`  in  32: CPU byte address, word-aligned.
- `write_data`  in  32: store data.
- `read_data`  out  32: load data; registered.
- `ready`  out  1: high = MEM stage may advance; low = freeze pipeline.
- `SRAM_DQ`  inout  16: SRAM data bus.
- `SRAM_ADDR`  out  18: SRAM half-word address.
- `SRAM_WE_N`  out  1: write enable, active low.
- `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each: tied low (0).

## Operation
- Offset `off = address - BASE_ADDR`, computed modulo 2^32.
- Word index `w = off[18:2]`.
- Low half goes to `SRAM_ADDR = {w,1'b0}` and carries bits [15:0]. High half goes to `{w,1'b1}` and carries bits [31:16].
- Bits above 18 and `off[1:0]` are ignored, so out-of-range addresses wrap.
- FSM states: IDLE, LOW, HIGH, DONE. A cycle counter `cnt` runs 0..ACCESS_CYCLES-1.
- IDLE:
  - If `rd_en|wr_en`, go to LOW with `cnt=0`.
  - If both are high, the request is treated as a write.
  - The operation type is latched on entry.
- LOW:
  - Drive the low address.
  - On a write, `SRAM_WE_N=0` and `SRAM_DQ=write_data[15:0]`.
  - On a read, `SRAM_WE_N=1` and DQ is high-Z.
  - When `cnt==ACCESS_CYCLES-1`: on a read, capture `SRAM_DQ` into `read_data[15:0]`. Then go to HIGH with `cnt=0`.
- HIGH: same as LOW using the high address and bits [31:16]. When `cnt==ACCESS_CYCLES-1`, capture into `read_data[31:16]` on a read, then go to DONE.
- DONE:
  - `SRAM_WE_N=1`, DQ high-Z.
  - Go to IDLE unconditionally.
- `ready = ~(rd_en|wr_en) | (state==DONE)`. This is combinational on the request so the freeze applies in the request cycle.
- `SRAM_DQ` is driven only during write LOW/HIGH states; otherwise it is 'z'.
- `SRAM_ADDR` is 0 in IDLE and DONE.
- `read_data` holds its last value until the next read overwrites it. A write never changes it.

## Timing
- Reset values: state IDLE, `cnt=0`, `read_data=0`, `SRAM_WE_N=1`, `SRAM_ADDR=0`, DQ high-Z. `ready` then follows the request inputs (1 if none).
- Reset mid-operation: return to IDLE immediately. Release WE_N (→1) and DQ. A half-written word may remain in SRAM. `read_data` goes to 0.
- Latency: a request seen at edge 0 enters LOW at edge 1. `ready` is high in cycle 2·ACCESS_CYCLES+1, i.e. 5 cycles for the default.
- `read_data` is valid in that same DONE cycle. The MEM/WB register captures it at the DONE→IDLE edge.
- Back-to-back: the next request may appear in the cycle after DONE. IDLE samples it, so there is no idle gap other than the IDLE cycle itself.
- The requester must hold `address`, `write_data` and the request stable until `ready`. The block does not re-latch `address`/`write_data`.
- `WE_N` is held low for all ACCESS_CYCLES of each write half. The address is stable for the whole half, which satisfies SRAM setup/hold at ≥2 cycles.

## Test plan
- Idle, no request, after reset → `ready=1`, `SRAM_WE_N=1`, DQ='z', `read_data=0`.
- Write 0x12345678 at address 1024 → SRAM[0]=0x5678, SRAM[1]=0x1234. `ready` is low for cycles 0–4 and high in cycle 5.
- Read address 1024 after that write → `read_data=0x12345678` in the DONE cycle; `ready` is high exactly one cycle. Then write 0xDEADBEEF at 1028 → SRAM[2]=0xBEEF, SRAM[3]=0xDEAD.
- Back-to-back read 1028 then read 1024, each request raised in the cycle after the previous DONE → `read_data` 0xDEADBEEF, then 0x12345678. No extra stall cycles.
- Assert `rst` during HIGH of a write of 0xAAAA5555 at 1032 → state IDLE, `SRAM_WE_N=1` immediately, `read_data=0`. SRAM[4]=0x5555 and SRAM[5] is unchanged. A new request afterwards completes normally.
- `rd_en=wr_en=1` at 1036 with data 0x0F0F0F0F → performed as a write: SRAM[6]=0x0F0F, SRAM[7]=0x0F0F. `read_data` is unchanged.
